hs_npu_mem_arbiter: RTL and testbench
=====================================

# hs_npu_mem_arbiter

Round-robin arbiter that shares the single `hs_npu_memory_interface` command/data channel between NPU memory requesters: input fetch, weight fetch, bias/sum fetch and result writeback. It sits between those requesters (in memory ordering) and the memory interface. It grants one outstanding burst transaction at a time and routes the completion back to the granted requester. It also supports a synchronous flush that cancels work not yet issued.

## Interface
- `NUM_REQ`, 4, number of requesters; index `NUM_REQ-1` is the writeback port by convention.
- `BURST_SIZE`, 2, 32-bit words per transaction (matches memory interface `BURST_SIZE`).
- `ADDR_WIDTH`, 32, address width (`uword`).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester request; held stable until `req_ready_o`.
- `req_write_i`  in  NUM_REQ  1 = write burst, 0 = read burst.
- `req_addr_i`  in  NUM_REQ×ADDR_WIDTH  burst base address.
- `req_wdata_i`  in  NUM_REQ×BURST_SIZE×32  write data.
- `req_ready_o`  out  NUM_REQ  one-hot, one-cycle request accept.
- `rsp_valid_o`  out  NUM_REQ  one-hot, one-cycle completion (read data valid / write done).
- `rsp_rdata_o`  out  BURST_SIZE×32  read data, shared; valid with `rsp_valid_o`.
- `flush_i`  in  1  cancel pending/unissued work.
- `busy_o`  out  1  transaction accepted and not yet completed.
- `mem_ready_i`  in  1  memory interface idle and can take a command.
- `mem_valid_i`  in  1  one-cycle completion from memory interface.
- `mem_read_ready_o`  out  1  one-cycle read command strobe.
- `mem_write_valid_o`  out  1  one-cycle write command strobe.
- `request_address`  out  ADDR_WIDTH  command address.
- `memory_data_out`  out  BURST_SIZE×32  write data to memory interface.
- `memory_data_in`  in  BURST_SIZE×32  read data from memory interface.

## Operation
- FSM states:
  - `IDLE`
    - If `!flush_i` and any `req_valid_i`: grant winner, pulse `req_ready_o[g]` combinationally.
    - Latch index, write flag, address and data, then go to `ISSUE`.
  - `ISSUE`
    - Wait for `mem_ready_i`.
    - In that cycle, pulse `mem_read_ready_o` or `mem_write_valid_o` with the latched `request_address`/`memory_data_out`, then go to `WAIT`.
  - `WAIT`
    - On `mem_valid_i`: register `memory_data_in` into `rsp_rdata_o`, go to `RESP`.
  - `RESP`
    - Pulse `rsp_valid_o[g]` (suppressed if drop flag set).
    - Clear drop flag, go to `IDLE`.
- Round-robin:
  - Pointer `ptr` starts at 0.
  - Winner is the first valid index at or after `ptr`, with wraparound (`NUM_REQ-1` → 0).
  - On grant, `ptr` ← g+1 mod NUM_REQ.
  - Any continuously valid requester is served within NUM_REQ grants.
- Flush:
  - `IDLE`: no grant that cycle.
  - `ISSUE`: return to `IDLE`, no command, no response.
  - `WAIT`: set drop flag; the transaction completes on memory, but its `rsp_valid_o` is suppressed.
  - `ptr` is unchanged by flush.
- `busy_o` = state ≠ `IDLE`.
- `req_write_i`/`req_addr_i`/`req_wdata_i` are sampled only at grant; later changes are ignored.

## Timing
- Reset values:
  - state `IDLE`, `ptr`=0, drop flag 0.
  - All `*_o` strobes 0.
  - `request_address`, `memory_data_out`, `rsp_rdata_o` all 0.
  - `busy_o`=0.
- Reset mid-transaction abandons it immediately; no response is issued.
- Latency:
  - Grant at edge E0 → command strobe at the earliest cycle after E0 (E0+1 if `mem_ready_i`).
  - `mem_valid_i` at cycle C → `rsp_valid_o` at C+1.
  - Minimum grant-to-response is 3 cycles.
- Back-to-back: next grant is possible in the cycle after `RESP`; at most one transaction is outstanding.
- `mem_valid_i` outside `WAIT` is ignored.
- `flush_i` and `mem_valid_i` in the same `WAIT` cycle: the response is dropped.
- `req_ready_o` and `rsp_valid_o` are never both asserted in the same cycle.

## Configuration
- `HS_NPU_ARB_WRITE_PRIORITY_EN`
  - Defined: requester `NUM_REQ-1` (writeback) wins whenever valid, overriding round-robin. Other requesters keep round-robin among themselves, and `ptr` advances only on their grants.
  - Undefined: pure round-robin over all requesters.

## Test plan
- Single read:
  - Stimulus: req 0, addr 0x1000, `mem_ready_i`=1, `mem_valid_i` 2 cycles after strobe with data {0xA5A5_0001, 0xA5A5_0002}.
  - Response: `mem_read_ready_o` one cycle with `request_address`=0x1000; `rsp_valid_o`=4'b0001 with that data one cycle after `mem_valid_i`.
- Fairness:
  - Stimulus: all 4 requesters continuously valid.
  - Response: grant order 0,1,2,3,0,1; each `req_ready_o` is one cycle. With `HS_NPU_ARB_WRITE_PRIORITY_EN` the order is 3,3,3…
- Write:
  - Stimulus: req 3 write, addr 0x2000, data {0x11, 0x22}.
  - Response: `mem_write_valid_o` with `memory_data_out`={0x11, 0x22}; `rsp_valid_o[3]` after `mem_valid_i`.
- Backpressure:
  - Stimulus: `mem_ready_i`=0 for 5 cycles after grant.
  - Response: no strobe for those cycles, `busy_o`=1; strobe in the first cycle `mem_ready_i`=1.
- Flush:
  - Stimulus: `flush_i` in `ISSUE`.
  - Response: no strobe, no response, `IDLE` next cycle.
  - Stimulus: `flush_i` in `WAIT`.
  - Response: `mem_valid_i` consumed, `rsp_valid_o` stays 0.
- Reset:
  - Stimulus: `rst_n` low while in `WAIT`.
  - Response: all outputs 0 immediately; after release, a new request is granted to requester 0 first.

Source files
------------

// File: rtl/hs_npu_mem_arbiter.sv
// Round-robin arbiter sharing one burst command/data channel between NPU requesters.
// Define HS_NPU_ARB_WRITE_PRIORITY_EN to give requester NUM_REQ-1 (writeback) absolute priority.
module hs_npu_mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BURST_SIZE = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    input  logic [NUM_REQ-1:0]                    req_write_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ-1:0][BURST_SIZE*32-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    output logic [NUM_REQ-1:0]                    rsp_valid_o,
    output logic [BURST_SIZE*32-1:0]              rsp_rdata_o,
    input  logic                                  flush_i,
    output logic                                  busy_o,
    input  logic                                  mem_ready_i,
    input  logic                                  mem_valid_i,
    output logic                                  mem_read_ready_o,
    output logic                                  mem_write_valid_o,
    output logic [ADDR_WIDTH-1:0]                 request_address,
    output logic [BURST_SIZE*32-1:0]              memory_data_out,
    input  logic [BURST_SIZE*32-1:0]              memory_data_in
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] ptr_inc;
    logic             win_found;
    logic             wr_q;
    logic             drop_q;
    logic             grant;

    // Scan downward so the lowest offset from ptr is the last (winning) write.
    always_comb begin
        win       = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req_valid_i[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
`ifdef HS_NPU_ARB_WRITE_PRIORITY_EN
        if (req_valid_i[NUM_REQ-1]) begin
            win       = IDX_W'(NUM_REQ - 1);
            win_found = 1'b1;
        end
`endif
    end

    assign ptr_inc = (int'(win) == NUM_REQ - 1) ? '0 : win + IDX_W'(1);

    always_comb begin
        state_nxt         = state;
        grant             = 1'b0;
        req_ready_o       = '0;
        rsp_valid_o       = '0;
        mem_read_ready_o  = 1'b0;
        mem_write_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n && !flush_i && win_found) begin
                    grant       = 1'b1;
                    req_ready_o = NUM_REQ'(1) << win;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (mem_ready_i) begin
                    mem_read_ready_o  = !wr_q;
                    mem_write_valid_o = wr_q;
                    state_nxt         = WAIT;
                end
            end
            WAIT: begin
                if (mem_valid_i) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = drop_q ? '0 : (NUM_REQ'(1) << gidx);
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            gidx            <= '0;
            wr_q            <= 1'b0;
            drop_q          <= 1'b0;
            request_address <= '0;
            memory_data_out <= '0;
            rsp_rdata_o     <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                gidx            <= win;
                wr_q            <= req_write_i[win];
                request_address <= req_addr_i[win];
                memory_data_out <= req_wdata_i[win];
`ifdef HS_NPU_ARB_WRITE_PRIORITY_EN
                if (int'(win) != NUM_REQ - 1) begin
                    ptr <= ptr_inc;
                end
`else
                ptr <= ptr_inc;
`endif
            end
            if (state == WAIT && mem_valid_i) begin
                rsp_rdata_o <= memory_data_in;
            end
            // A flush after issue cannot stop memory, so only the response is hidden.
            if (state == WAIT && flush_i) begin
                drop_q <= 1'b1;
            end else if (state == RESP) begin
                drop_q <= 1'b0;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_hs_npu_mem_arbiter.sv
// Bench for hs_npu_mem_arbiter: directed cycle table, fairness/reset sequences,
// and randomized traffic against a transaction-level model.
module tb_hs_npu_mem_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_write;
    logic [N-1:0][31:0]   req_addr;
    logic [N-1:0][DW-1:0] req_wdata;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 flush;
    logic                 busy;
    logic                 mem_ready;
    logic                 mem_valid;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [31:0]          req_address;
    logic [DW-1:0]        mem_dout;
    logic [DW-1:0]        mem_din;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    hs_npu_mem_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_write_i       (req_write),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .req_ready_o       (req_ready),
        .rsp_valid_o       (rsp_valid),
        .rsp_rdata_o       (rsp_rdata),
        .flush_i           (flush),
        .busy_o            (busy),
        .mem_ready_i       (mem_ready),
        .mem_valid_i       (mem_valid),
        .mem_read_ready_o  (mem_rd),
        .mem_write_valid_o (mem_wr),
        .request_address   (req_address),
        .memory_data_out   (mem_dout),
        .memory_data_in    (mem_din)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, 64'(req_ready), 64'd0);
        chk({nm, "_rsp"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_strobes"}, 64'({mem_rd, mem_wr}), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_addr"}, 64'(req_address), 64'd0);
        chk({nm, "_wdata"}, mem_dout, 64'd0);
        chk({nm, "_rdata"}, rsp_rdata, 64'd0);
    endtask

    // Winner by the round-robin rule: first valid index at or after p.
    function automatic int pick(input logic [N-1:0] v, input int p);
        int j;
`ifdef HS_NPU_ARB_WRITE_PRIORITY_EN
        if (v[N-1]) return N - 1;
`endif
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] x);
        for (int i = 0; i < N; i++) begin
            if (x[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  rv;
        logic        fl;
        logic        mr;
        logic        mv;
        logic [63:0] md;
        logic [3:0]  rr;
        logic        rd;
        logic        wr;
        logic [3:0]  rs;
        logic        bz;
        logic [31:0] ea;
        logic [63:0] ed;
    } vec_t;

    function automatic vec_t v(
        input logic [3:0] rv, input logic fl, input logic mr, input logic mv,
        input logic [63:0] md, input logic [3:0] rr, input logic rd,
        input logic wr, input logic [3:0] rs, input logic bz,
        input logic [31:0] ea, input logic [63:0] ed);
        vec_t r;
        r.rv = rv; r.fl = fl; r.mr = mr; r.mv = mv; r.md = md;
        r.rr = rr; r.rd = rd; r.wr = wr; r.rs = rs; r.bz = bz;
        r.ea = ea; r.ed = ed;
        return r;
    endfunction

    // Transaction-level reference model state.
    int          m_ptr;
    bit          m_active;
    bit          m_issued;
    bit          m_done;
    bit          m_drop;
    int          m_idx;
    bit          m_wr;
    logic [31:0] m_addr;
    logic [63:0] m_data;
    logic [63:0] m_rdata;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        int          got[$];
        int          exp_order[6];
        int          cyc;
        int          g;
        bit          prev_rr;
        logic [N-1:0] gmask;
        logic [3:0]  e_rr;
        logic        e_rd;
        logic        e_wr;
        logic [3:0]  e_rs;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] wd3;

        d1  = 64'hA5A5_0002_A5A5_0001;
        d2  = 64'h1234_5678_9ABC_DEF0;
        wd3 = {32'h0000_0022, 32'h0000_0011};

        req_valid    = 4'b1111;
        req_write    = 4'b1000;
        req_addr[0]  = 32'h1000;
        req_addr[1]  = 32'h1100;
        req_addr[2]  = 32'h1200;
        req_addr[3]  = 32'h2000;
        req_wdata[0] = 64'h0A0A;
        req_wdata[1] = 64'h1B1B;
        req_wdata[2] = 64'h2C2C;
        req_wdata[3] = wd3;
        flush        = 1'b0;
        mem_ready    = 1'b0;
        mem_valid    = 1'b0;
        mem_din      = '0;

        //       rv    fl mr mv md    rr    rd wr rs    bz ea      ed
        tbl.push_back(v(4'b0001, 0, 1, 0, 0,  4'b0001, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(v(4'b0000, 0, 1, 0, 0,  4'b0000, 1, 0, 4'b0000, 1, 32'h1000, 0));
        tbl.push_back(v(4'b0000, 0, 0, 0, 0,  4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 1, d1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 0, 0,  4'b0000, 0, 0, 4'b0001, 1, 0, d1));
        tbl.push_back(v(4'b1000, 0, 0, 0, 0,  4'b1000, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(v(4'b0000, 0, 1, 0, 0,  4'b0000, 0, 1, 4'b0000, 1, 32'h2000, wd3));
        tbl.push_back(v(4'b0000, 0, 0, 1, d2, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 0, 0,  4'b0000, 0, 0, 4'b1000, 1, 0, d2));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0,  4'b0010, 0, 0, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 1, 0, 0,  4'b0000, 1, 0, 4'b0000, 1, 32'h1100, 0));
        tbl.push_back(v(4'b0000, 0, 0, 1, d1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 0, 0,  4'b0000, 0, 0, 4'b0010, 1, 0, d1));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0,  4'b0100, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(v(4'b0000, 1, 1, 0, 0,  4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 1, d2, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0,  4'b0001, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(v(4'b0000, 0, 1, 0, 0,  4'b0000, 1, 0, 4'b0000, 1, 32'h1000, 0));
        tbl.push_back(v(4'b0000, 1, 0, 0, 0,  4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 1, d2, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 0, 0,  4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 1, d1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0,  4'b0010, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(v(4'b0000, 0, 1, 0, 0,  4'b0000, 1, 0, 4'b0000, 1, 32'h1100, 0));
        tbl.push_back(v(4'b0000, 1, 0, 1, d1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 0, 0,  4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        tbl.push_back(v(4'b1111, 1, 0, 0, 0,  4'b0000, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(v(4'b0000, 0, 0, 0, 0,  4'b0000, 0, 0, 4'b0000, 0, 0, 0));

        // Reset state, with every requester asking.
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            req_valid = tbl[i].rv;
            flush     = tbl[i].fl;
            mem_ready = tbl[i].mr;
            mem_valid = tbl[i].mv;
            mem_din   = tbl[i].md;
            #2;
            chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].rr));
            chk($sformatf("tbl%0d_rd", i), 64'(mem_rd), 64'(tbl[i].rd));
            chk($sformatf("tbl%0d_wr", i), 64'(mem_wr), 64'(tbl[i].wr));
            chk($sformatf("tbl%0d_rsp", i), 64'(rsp_valid), 64'(tbl[i].rs));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bz));
            if (tbl[i].rd || tbl[i].wr)
                chk($sformatf("tbl%0d_addr", i), 64'(req_address), 64'(tbl[i].ea));
            if (tbl[i].wr)
                chk($sformatf("tbl%0d_wdata", i), mem_dout, tbl[i].ed);
            if (tbl[i].rs != 4'b0000)
                chk($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].ed);
            tick();
        end

        // Reset while waiting for memory.
        req_valid = 4'b0100;
        flush     = 1'b0;
        mem_valid = 1'b0;
        mem_ready = 1'b0;
        #2;
        chk("rstw_grant", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid = 4'b0000;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #2;
        chk("rstw_busy", 64'(busy), 64'd1);
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        chk_all_zero("rstw");
        tick();
        tick();
        mem_ready = 1'b1;
        mem_valid = 1'b1;
        rst_n     = 1'b1;

        // Fairness with all requesters held valid.
`ifdef HS_NPU_ARB_WRITE_PRIORITY_EN
        exp_order = '{3, 3, 3, 3, 3, 3};
`else
        exp_order = '{0, 1, 2, 3, 0, 1};
`endif
        cyc     = 0;
        prev_rr = 1'b0;
        while (got.size() < 6 && cyc < 60) begin
            #2;
            if (prev_rr)
                chk("fair_pulse", 64'(req_ready), 64'd0);
            if (req_ready != 4'b0000) begin
                chk("fair_onehot", 64'($countones(req_ready)), 64'd1);
                got.push_back(idx_of(req_ready));
            end
            chk("fair_no_overlap", 64'(req_ready & rsp_valid), 64'd0);
            prev_rr = (req_ready != 4'b0000);
            tick();
            cyc++;
        end
        chk("fair_count", 64'(got.size()), 64'd6);
        foreach (got[i])
            chk($sformatf("fair_order%0d", i), 64'(got[i]), 64'(exp_order[i]));

        // Randomized traffic from a clean reset.
        req_valid = '0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        m_ptr    = 0;
        m_active = 0;
        m_issued = 0;
        m_done   = 0;
        m_drop   = 0;
        m_idx    = 0;
        m_wr     = 0;
        m_addr   = '0;
        m_data   = '0;
        m_rdata  = '0;
        gmask    = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (gmask[i] || (!req_valid[i] && $urandom_range(3) == 0)) begin
                    req_valid[i] = !gmask[i];
                    req_write[i] = 1'($urandom_range(1));
                    req_addr[i]  = $urandom;
                    req_wdata[i] = {$urandom, $urandom};
                end
            end
            flush     = ($urandom_range(15) == 0);
            mem_ready = ($urandom_range(2) != 0);
            mem_valid = ($urandom_range(2) == 0);
            mem_din   = {$urandom, $urandom};
            #2;
            e_rr = '0;
            e_rd = 1'b0;
            e_wr = 1'b0;
            e_rs = '0;
            g    = pick(req_valid, m_ptr);
            if (!m_active) begin
                if (!flush && g >= 0) e_rr = 4'b0001 << g;
            end else if (!m_issued) begin
                if (mem_ready && !flush) begin
                    e_rd = !m_wr;
                    e_wr = m_wr;
                end
            end else if (m_done) begin
                e_rs = m_drop ? 4'b0000 : (4'b0001 << m_idx);
            end
            chk("rnd_ready", 64'(req_ready), 64'(e_rr));
            chk("rnd_rd", 64'(mem_rd), 64'(e_rd));
            chk("rnd_wr", 64'(mem_wr), 64'(e_wr));
            chk("rnd_rsp", 64'(rsp_valid), 64'(e_rs));
            chk("rnd_busy", 64'(busy), 64'(m_active));
            if (e_rd || e_wr)
                chk("rnd_addr", 64'(req_address), 64'(m_addr));
            if (e_wr)
                chk("rnd_wdata", mem_dout, m_data);
            if (e_rs != 4'b0000)
                chk("rnd_rdata", rsp_rdata, m_rdata);

            if (!m_active) begin
                if (e_rr != 4'b0000) begin
                    m_active = 1;
                    m_issued = 0;
                    m_done   = 0;
                    m_idx    = g;
                    m_wr     = req_write[g];
                    m_addr   = req_addr[g];
                    m_data   = req_wdata[g];
`ifdef HS_NPU_ARB_WRITE_PRIORITY_EN
                    if (g != N - 1) m_ptr = (g + 1) % N;
`else
                    m_ptr = (g + 1) % N;
`endif
                end
            end else if (!m_issued) begin
                if (flush) m_active = 0;
                else if (mem_ready) m_issued = 1;
            end else if (!m_done) begin
                if (flush) m_drop = 1;
                if (mem_valid) begin
                    m_done  = 1;
                    m_rdata = mem_din;
                end
            end else begin
                m_active = 0;
                m_drop   = 0;
            end
            gmask = req_ready;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
